// File: rtl/bnn_pkg.sv
// Shared constants and helpers for the binary-weight 5x5 convolution core.
package bnn_pkg;
    localparam int DW   = 32;
    localparam int K    = 5;
    localparam int W0   = 28;
    localparam int W1   = 12;
    localparam int NTAP = K * K;
    localparam int OUT0 = (W0 - K + 1) * (W0 - K + 1);
    localparam int OUT1 = (W1 - K + 1) * (W1 - K + 1);
    localparam int CW   = $clog2(W0);

    typedef logic [CW-1:0] idx_t;

    // Last valid row/column index for the selected layer.
    function automatic idx_t last_index(input logic sel);
        return sel ? idx_t'(W1 - 1) : idx_t'(W0 - 1);
    endfunction
endpackage

// File: rtl/bnn_line_window.sv
// K-1 line buffers feeding a KxK sliding tap array; one new column per shift.
module bnn_line_window
    import bnn_pkg::*;
(
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  shift_en,
    input  logic                  width_sel,
    input  logic [DW-1:0]         din,
    output logic [NTAP*DW-1:0]    taps
);
    idx_t          ptr_reg;
    idx_t          ptr_next;
    idx_t          rd_addr;
    logic [DW-1:0] col_vec [K];

    // Read the address the next accepted pixel will use so the registered
    // read data is ready without a bubble, even across gaps.
    always_comb begin
        ptr_next = (ptr_reg >= last_index(width_sel)) ? '0 : ptr_reg + 1'b1;
        rd_addr  = shift_en ? ptr_next : ptr_reg;
    end

    always_ff @(posedge clk or posedge rstn) begin
        if (rstn) begin
            ptr_reg <= '0;
        end else if (shift_en) begin
            ptr_reg <= ptr_next;
        end
    end

    genvar gi, gj;
    generate
        for (gi = 0; gi < K - 1; gi++) begin : g_line
            logic [DW-1:0] mem [W0];
            logic [DW-1:0] q;
            logic [DW-1:0] wr_data;
            if (gi == 0) begin : g_first
                assign wr_data = din;
            end else begin : g_rest
                assign wr_data = g_line[gi-1].q;
            end
            always_ff @(posedge clk) begin
                q <= mem[rd_addr];
                if (shift_en) begin
                    mem[ptr_reg] <= wr_data;
                end
            end
            // Line gi holds row r-1-gi; oldest row lands in window row 0.
            assign col_vec[K-2-gi] = q;
        end
        assign col_vec[K-1] = din;

        for (gi = 0; gi < K; gi++) begin : g_trow
            for (gj = 0; gj < K; gj++) begin : g_tcol
                logic [DW-1:0] t;
                logic [DW-1:0] t_in;
                if (gj == K - 1) begin : g_edge
                    assign t_in = col_vec[gi];
                end else begin : g_inner
                    assign t_in = g_trow[gi].g_tcol[gj+1].t;
                end
                always_ff @(posedge clk) begin
                    if (shift_en) begin
                        t <= t_in;
                    end
                end
                assign taps[(NTAP-1-(gi*K+gj))*DW +: DW] = t;
            end
        end
    endgenerate
endmodule

// File: rtl/bnn_conv_core.sv
// Streaming 5x5 binary-weight convolution: raster pixels in, valid-window sums out
// two clocks after the completing pixel is accepted.
module bnn_conv_core
    import bnn_pkg::*;
(
    input  logic          clk,
    input  logic          rstn,
    input  logic          start,
    input  logic          state,
    input  logic          weight_en,
    input  logic          weight,
    input  logic          din_valid,
    input  logic [DW-1:0] din,
    output logic [DW-1:0] dout,
    output logic          ovalid,
    output logic          done
);
    idx_t              row_reg;
    idx_t              col_reg;
    logic              state_reg;
    logic [NTAP-1:0]   wreg;
    logic              accept;
    logic              first_px;
    logic              sel;
    idx_t              last_col;
    logic              frame_last;
    logic              win_ok;
    logic [NTAP*DW-1:0] taps;
    logic [K*DW-1:0]   psum_bus;
    logic [DW-1:0]     total;
    logic              win_v_reg, win_d_reg;
    logic              sum_v_reg, sum_d_reg;

    // The layer is taken straight from the port on a frame's first pixel.
    always_comb begin
        accept     = start & din_valid;
        first_px   = (row_reg == '0) && (col_reg == '0);
        sel        = first_px ? state : state_reg;
        last_col   = last_index(sel);
        frame_last = (row_reg == last_col) && (col_reg == last_col);
        win_ok     = (row_reg >= idx_t'(K - 1)) && (col_reg >= idx_t'(K - 1));
    end

    always_ff @(posedge clk or posedge rstn) begin
        if (rstn) begin
            row_reg   <= '0;
            col_reg   <= '0;
            state_reg <= 1'b0;
        end else if (accept) begin
            if (first_px) begin
                state_reg <= state;
            end
            if (col_reg == last_col) begin
                col_reg <= '0;
                row_reg <= frame_last ? '0 : row_reg + 1'b1;
            end else begin
                col_reg <= col_reg + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rstn) begin
        if (rstn) begin
            wreg <= '0;
        end else if (weight_en) begin
            wreg <= {wreg[NTAP-2:0], weight};
        end
    end

    bnn_line_window u_window (
        .clk       (clk),
        .rstn      (rstn),
        .shift_en  (accept),
        .width_sel (sel),
        .din       (din),
        .taps      (taps)
    );

    // Stage 1: one signed +/- sum per kernel row; weight bit and tap share a slice index.
    genvar gi;
    generate
        for (gi = 0; gi < K; gi++) begin : g_row
            logic [DW-1:0] row_sum;
            logic [DW-1:0] psum_reg;
            always_comb begin
                row_sum = '0;
                for (int j = 0; j < K; j++) begin
                    if (wreg[NTAP-1-(gi*K+j)]) begin
                        row_sum = row_sum + taps[(NTAP-1-(gi*K+j))*DW +: DW];
                    end else begin
                        row_sum = row_sum - taps[(NTAP-1-(gi*K+j))*DW +: DW];
                    end
                end
            end
            always_ff @(posedge clk) begin
                psum_reg <= row_sum;
            end
            assign psum_bus[gi*DW +: DW] = psum_reg;
        end
    endgenerate

    always_comb begin
        total = '0;
        for (int i = 0; i < K; i++) begin
            total = total + psum_bus[i*DW +: DW];
        end
    end

    always_ff @(posedge clk or posedge rstn) begin
        if (rstn) begin
            win_v_reg <= 1'b0;
            win_d_reg <= 1'b0;
            sum_v_reg <= 1'b0;
            sum_d_reg <= 1'b0;
            ovalid    <= 1'b0;
            done      <= 1'b0;
            dout      <= '0;
        end else begin
            win_v_reg <= accept & win_ok;
            win_d_reg <= accept & frame_last;
            sum_v_reg <= win_v_reg;
            sum_d_reg <= win_d_reg;
            ovalid    <= sum_v_reg;
            done      <= sum_d_reg;
            if (sum_v_reg) begin
                dout <= total;
            end
        end
    end
endmodule

// File: tb/tb_bnn_conv_core.sv
// Scoreboard bench: a direct convolution model queues each expected result with its due cycle.
module tb_bnn_conv_core;
    import bnn_pkg::*;

    logic          clk = 1'b0;
    logic          rstn, start, state, weight_en, weight, din_valid;
    logic [DW-1:0] din, dout;
    logic          ovalid, done;

    always #5 clk = ~clk;

    bnn_conv_core dut (
        .clk       (clk),
        .rstn      (rstn),
        .start     (start),
        .state     (state),
        .weight_en (weight_en),
        .weight    (weight),
        .din_valid (din_valid),
        .din       (din),
        .dout      (dout),
        .ovalid    (ovalid),
        .done      (done)
    );

    typedef struct {
        logic [DW-1:0] dout;
        logic          done;
        int            due;
    } exp_t;

    exp_t          sb[$];
    exp_t          h;
    logic          exp_v;
    int            cyc = 0;
    int            errors = 0;
    int            checks = 0;
    int            n_out = 0;
    logic [DW-1:0] last_dout_exp = '0;
    logic [24:0]   wmodel = '0;
    logic [DW-1:0] img [W0][W0];

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: exactly the queued results, at their due cycle, nothing else.
    always @(negedge clk) begin
        if (rstn) begin
            sb.delete();
            last_dout_exp = '0;
        end
        exp_v = (sb.size() > 0) && (sb[0].due == cyc);
        checks++;
        assert (ovalid === exp_v) else begin
            errors++;
            $error("FAIL ovalid cyc=%0d observed=%b expected=%b", cyc, ovalid, exp_v);
        end
        if (ovalid === 1'b1) n_out++;
        if (exp_v) begin
            h = sb.pop_front();
            last_dout_exp = h.dout;
            $display("result cyc=%0d dout=%0h done=%b", cyc, dout, done);
            checks++;
            assert (dout === h.dout) else begin
                errors++;
                $error("FAIL dout cyc=%0d observed=%0h expected=%0h", cyc, dout, h.dout);
            end
            checks++;
            assert (done === h.done) else begin
                errors++;
                $error("FAIL done cyc=%0d observed=%b expected=%b", cyc, done, h.done);
            end
        end else begin
            checks++;
            assert (done === 1'b0) else begin
                errors++;
                $error("FAIL done_idle cyc=%0d observed=%b expected=0", cyc, done);
            end
            checks++;
            assert (dout === last_dout_exp) else begin
                errors++;
                $error("FAIL dout_hold cyc=%0d observed=%0h expected=%0h", cyc, dout, last_dout_exp);
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    function automatic logic [DW-1:0] conv(input int r0, input int c0);
        logic [DW-1:0] acc = '0;
        for (int i = 0; i < K; i++) begin
            for (int j = 0; j < K; j++) begin
                if (wmodel[24-(i*K+j)]) acc = acc + img[r0+i][c0+j];
                else                    acc = acc - img[r0+i][c0+j];
            end
        end
        return acc;
    endfunction

    task automatic load_weights(input logic [24:0] v);
        for (int k = 24; k >= 0; k--) begin
            @(negedge clk);
            weight_en = 1'b1;
            weight    = v[k];
        end
        @(negedge clk);
        weight_en = 1'b0;
        wmodel    = v;
    endtask

    // mode 0: every pixel = val; mode 1: pixel = W*r + c. gap: idle percentage.
    task automatic send_frame(input int lay, input int mode, input logic [DW-1:0] val,
                              input int gap, input int stop_at);
        int   w = lay ? W1 : W0;
        int   n = 0;
        exp_t e;
        for (int r = 0; r < w; r++) begin
            for (int c = 0; c < w; c++) begin
                if (stop_at >= 0 && n == stop_at) return;
                while (gap > 0 && int'($urandom_range(99)) < gap) begin
                    @(negedge clk);
                    din = $urandom;
                    if ($urandom_range(1) == 1) begin
                        start = 1'b1; din_valid = 1'b0;
                    end else begin
                        start = 1'b0; din_valid = 1'b1;
                    end
                end
                @(negedge clk);
                start     = 1'b1;
                din_valid = 1'b1;
                state     = (r == 0 && c == 0) ? lay[0] : ~lay[0];
                img[r][c] = (mode == 1) ? DW'(w * r + c) : val;
                din       = img[r][c];
                if (r >= K - 1 && c >= K - 1) begin
                    e.dout = conv(r - (K - 1), c - (K - 1));
                    e.done = (r == w - 1) && (c == w - 1);
                    e.due  = cyc + 3;
                    sb.push_back(e);
                end
                n++;
            end
        end
    endtask

    task automatic idle_drain(input int n_before, input int n_expect, input string tag);
        int t = 0;
        @(negedge clk);
        start = 1'b0; din_valid = 1'b0;
        while (sb.size() > 0 && t < 200) begin
            @(negedge clk);
            t++;
        end
        @(negedge clk);
        checks++;
        assert (sb.size() == 0) else begin
            errors++;
            $error("FAIL %s_drain observed=%0d pending expected=0", tag, sb.size());
        end
        checks++;
        assert (n_out - n_before == n_expect) else begin
            errors++;
            $error("FAIL %s_count observed=%0d expected=%0d", tag, n_out - n_before, n_expect);
        end
    endtask

    int base;

    initial begin
        rstn = 1'b1; start = 1'b0; state = 1'b0; weight_en = 1'b0; weight = 1'b0;
        din_valid = 1'b0; din = '0;
        repeat (3) @(negedge clk);
        checks += 3;
        assert (dout === '0)    else begin errors++; $error("FAIL reset_dout observed=%0h expected=0", dout); end
        assert (ovalid === 1'b0) else begin errors++; $error("FAIL reset_ovalid observed=%b expected=0", ovalid); end
        assert (done === 1'b0)  else begin errors++; $error("FAIL reset_done observed=%b expected=0", done); end
        rstn = 1'b0;

        // Layer 1 const 2, then wrap frame, then layer 0 ramps, all back-to-back.
        load_weights('1);
        base = n_out;
        send_frame(1, 0, 32'd2, 0, -1);
        send_frame(1, 0, 32'h7FFF_FFFF, 0, -1);
        send_frame(0, 1, '0, 0, -1);
        send_frame(0, 1, '0, 30, -1);
        idle_drain(base, 2 * OUT1 + 2 * OUT0, "mixed");

        // Reset mid-frame with results in flight.
        send_frame(0, 1, '0, 0, 300);
        @(posedge clk);
        #2 rstn = 1'b1;
        start = 1'b0; din_valid = 1'b0;
        #1;
        checks += 3;
        assert (ovalid === 1'b0) else begin errors++; $error("FAIL midrst_ovalid observed=%b expected=0", ovalid); end
        assert (done === 1'b0)   else begin errors++; $error("FAIL midrst_done observed=%b expected=0", done); end
        assert (dout === '0)     else begin errors++; $error("FAIL midrst_dout observed=%0h expected=0", dout); end
        repeat (2) @(negedge clk);
        rstn = 1'b0;
        wmodel = '0;

        load_weights('1);
        base = n_out;
        send_frame(0, 1, '0, 0, -1);
        idle_drain(base, OUT0, "after_rst");

        load_weights('0);
        base = n_out;
        send_frame(0, 0, 32'd1, 0, -1);
        idle_drain(base, OUT0, "zeros");

        load_weights(25'h100_0000);
        base = n_out;
        send_frame(0, 0, 32'd1, 0, -1);
        idle_drain(base, OUT0, "single");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
